// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder family.
// Mode encoding for the in_sub flag and the segment-width calculation.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full adder cell; the ripple building block of adder_seg.
module adder_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple segment built from adder_1bit cells.
// One instance per pipeline stage; carries in and out through cin_i/cout_o.
module adder_seg #(
  parameter int SEG = 3
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o
);

  logic [SEG:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    adder_1bit u_bit (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .cin_i (carry[i]),
      .sum_o (sum_o[i]),
      .cout_o(carry[i+1])
    );
  end

  assign cout_o = carry[SEG];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract split into STAGES ripple segments with valid/ready flow.
// Optional saturating output when ADDER_PIPE_SAT_EN is defined.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("adder_pipe: WIDTH must be >= 2 and divisible by STAGES in 1..WIDTH");
  end

  // Handshake: a beat moves on a rising edge when valid && ready on the same side.
  // The whole pipe shares one enable, so a stalled output freezes every stage.
  logic              advance;
  logic [STAGES-1:0] v_d, v_q;
  logic [STAGES-1:0] sub_d, sub_q;
  logic [STAGES-1:0] c_in, c_d, c_q;
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  res_in[STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];

  assign advance   = !v_q[LAST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[LAST];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] seg_sum;

    if (k == 0) begin : g_head
      // Subtract is A + ~B + 1: invert B once here, carry-in comes from the mode flag.
      assign v_d[k]    = in_valid;
      assign a_d[k]    = in_a;
      assign b_d[k]    = in_b ^ {WIDTH{in_sub == MODE_SUB}};
      assign sub_d[k]  = in_sub;
      assign c_in[k]   = (in_sub == MODE_SUB);
      assign res_in[k] = '0;
    end else begin : g_body
      assign v_d[k]    = v_q[k-1];
      assign a_d[k]    = a_q[k-1];
      assign b_d[k]    = b_q[k-1];
      assign sub_d[k]  = sub_q[k-1];
      assign c_in[k]   = c_q[k-1];
      assign res_in[k] = res_q[k-1];
    end

    adder_seg #(
      .SEG(SEG)
    ) u_seg (
      .a_i   (a_d[k][k*SEG +: SEG]),
      .b_i   (b_d[k][k*SEG +: SEG]),
      .cin_i (c_in[k]),
      .sum_o (seg_sum),
      .cout_o(c_d[k])
    );

    // Upper result bits are still zero at this point, so OR-ing places the new segment.
    assign res_d[k] = res_in[k] | (WIDTH'(seg_sum) << (k * SEG));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      sub_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else if (advance) begin
      v_q   <= v_d;
      sub_q <= sub_d;
      c_q   <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  // Top bit is carry for add and borrow (inverted carry) for subtract.
  logic top_flag;
  assign top_flag = (sub_q[LAST] == MODE_SUB) ? ~c_q[LAST] : c_q[LAST];

`ifdef ADDER_PIPE_SAT_EN
  always_comb begin
    out_sum = {1'b0, res_q[LAST]};
    if (top_flag) begin
      out_sum = (sub_q[LAST] == MODE_SUB) ? {1'b1, {WIDTH{1'b0}}} : {1'b1, {WIDTH{1'b1}}};
    end
  end
`else
  assign out_sum = {top_flag, res_q[LAST]};
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: vector table, random streaming, stall, reset and width sweep.
module tb_adder_pipe;

  localparam int W  = 9;
  localparam int S  = 3;
  localparam int SW = 16;
`ifdef ADDER_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic         in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [W-1:0] in_a, in_b;
  logic [W:0]   out_sum;

  logic          sw_valid, sw_sub;
  logic [SW-1:0] sw_a, sw_b;
  logic          sw_ready[3];
  logic          sw_ov[3];
  logic [SW:0]   sw_sum[3];
  int            sw_stages[3] = '{1, 4, 16};

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  adder_pipe #(.WIDTH(SW), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[0]),
    .in_a(sw_a), .in_b(sw_b), .in_sub(sw_sub),
    .out_valid(sw_ov[0]), .out_ready(1'b1), .out_sum(sw_sum[0])
  );

  adder_pipe #(.WIDTH(SW), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[1]),
    .in_a(sw_a), .in_b(sw_b), .in_sub(sw_sub),
    .out_valid(sw_ov[1]), .out_ready(1'b1), .out_sum(sw_sum[1])
  );

  adder_pipe #(.WIDTH(SW), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[2]),
    .in_a(sw_a), .in_b(sw_b), .in_sub(sw_sub),
    .out_valid(sw_ov[2]), .out_ready(1'b1), .out_sum(sw_sum[2])
  );

  // ---------------- reference model and scoreboard ----------------
  int         errors = 0;
  int         checks = 0;
  logic [W:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         out_cnt = 0;
  int         first_out = 0;
  int         last_out = 0;

  function automatic logic [SW:0] model(input int w, input int unsigned a, input int unsigned b,
                                        input bit sub);
    longint m, sa, sb, low, r;
    bit     top;
    m  = longint'(1) << w;
    sa = longint'(a);
    sb = longint'(b);
    if (!sub) begin
      low = (sa + sb) % m;
      top = (sa + sb) >= m;
    end else begin
      low = (sa - sb + m) % m;
      top = sa < sb;
    end
    if (SAT && top) low = sub ? 0 : m - 1;
    r = (longint'(top) << w) | low;
    return r[SW:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h required no result (cycle %0d)", out_sum, cyc);
      end else begin
        check("stream_data", out_sum, exp_q.pop_front());
      end
      if (out_cnt == 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(posedge clk);
    #1;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(W, a, b, sub));
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL drive_timeout: got in_ready=0 required 1 within 50 cycles");
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int exp_cnt);
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    check({name, "_empty"}, exp_q.size(), 0);
    check({name, "_count"}, out_cnt, exp_cnt);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W:0]   exp;
    string        name;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [W:0]  held;
    int          lat;
    int          n_valid;
    int          sw_lat[3];
    logic [SW:0] sw_got[3];
    int unsigned va[3], vb[3];
    bit          vs[3];

    vecs[0] = '{9'd511, 9'd1,   1'b0, SAT ? 10'h3FF : 10'h200, "add_511_1"};
    vecs[1] = '{9'd0,   9'd0,   1'b0, 10'h000,                 "add_0_0"};
    vecs[2] = '{9'd7,   9'd5,   1'b1, 10'h002,                 "sub_7_5"};
    vecs[3] = '{9'd5,   9'd7,   1'b1, SAT ? 10'h200 : 10'h3FE, "sub_5_7"};
    vecs[4] = '{9'd300, 9'd100, 1'b0, 10'h190,                 "add_300_100"};
    vecs[5] = '{9'd0,   9'd1,   1'b1, SAT ? 10'h200 : 10'h3FF, "sub_0_1"};
    vecs[6] = '{9'd256, 9'd256, 1'b0, SAT ? 10'h3FF : 10'h200, "add_256_256"};
    vecs[7] = '{9'd511, 9'd511, 1'b1, 10'h000,                 "sub_511_511"};

    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0;

    // Reset state, observed without any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sw16_sum", sw_sum[2], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table: single beats, exact latency and value.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      in_a = vecs[i].a; in_b = vecs[i].b; in_sub = vecs[i].sub; in_valid = 1'b1;
      @(negedge clk);
      check({vecs[i].name, "_ready"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 10);
      check({vecs[i].name, "_latency"}, lat, S);
      check({vecs[i].name, "_sum"}, out_sum, vecs[i].exp);
    end
    @(negedge clk);

    // Streaming: 20 random back-to-back beats, full throughput.
    mon_en = 1'b1;
    out_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive_beat(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
    end
    go_idle();
    drain("stream", 20);
    check("stream_no_gaps", last_out - first_out, 19);

    // Backpressure: fill with out_ready low, stall 4 cycles with a beat waiting.
    @(posedge clk);
    #1 out_ready = 1'b0;
    out_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
    end
    fork
      drive_beat(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
      begin
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          if (j == 0) begin
            held = out_sum;
            check("stall_head_data", held, exp_q[0]);
          end
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_sum", out_sum, held);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    go_idle();
    drain("backpressure", 4);

    // Reset with three beats in flight.
    mon_en = 1'b0;
    drive_beat(9'd511, 9'd1, 1'b0);
    drive_beat(9'd100, 9'd27, 1'b0);
    drive_beat(9'd5, 9'd7, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("inflight_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sum", out_sum, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    check("midrst_ready_held", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    n_valid = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) n_valid++;
    end
    check("postrst_no_stale", n_valid, 0);

    // Width sweep: WIDTH=16 at STAGES 1, 4 and 16.
    va = '{65535, 1000, 40000};
    vb = '{65535, 3000, 12345};
    vs = '{1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      @(posedge clk);
      #1;
      sw_a = SW'(va[v]); sw_b = SW'(vb[v]); sw_sub = vs[v]; sw_valid = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) check("sweep_ready", sw_ready[d], 1);
      @(posedge clk);
      #1 sw_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        sw_lat[d] = 0;
        sw_got[d] = '0;
      end
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
          if (sw_lat[d] == 0 && sw_ov[d]) begin
            sw_lat[d] = n;
            sw_got[d] = sw_sum[d];
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        check($sformatf("sweep_s%0d_latency", sw_stages[d]), sw_lat[d], sw_stages[d]);
        check($sformatf("sweep_s%0d_sum", sw_stages[d]), sw_got[d], model(SW, va[v], vb[v], vs[v]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the fixed 9-bit ripple adder.
- Splits a WIDTH-bit add or subtract into STAGES ripple segments, with a registered carry between segments.
- Valid/ready handshake on input and output, so it drops into streaming datapaths between producer and consumer blocks.
- Result is WIDTH+1 bits: carry-out, or borrow in subtract mode.

Parameters:
- WIDTH, 9: operand width in bits. Must be at least 2.
- STAGES, 3: number of pipeline segments. Range 1..WIDTH, and WIDTH must be divisible by STAGES; elaboration error otherwise.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- in_sub  in  1  0 = A+B; 1 = A-B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH+1  result; see the arithmetic rules below.

Behaviour:
- Segment width is SEG = WIDTH/STAGES. Stage k computes bits [k*SEG +: SEG] using the carry registered by stage k-1.
- Stage 0 carry-in:
  - add: 0.
  - subtract: 1, with B inverted.
- Operand skew: upper segments of A, B and the sub flag are delayed through registers until their stage.
- Result de-skew: lower result segments are delayed so all bits of one beat leave together.
- Add: out_sum = {carry_out, sum}, i.e. the exact A+B.
- Subtract: out_sum[WIDTH-1:0] = (A-B) mod 2^WIDTH, and out_sum[WIDTH] = borrow = ~carry_out.
- Latency: exactly STAGES cycles from an accepted beat to out_valid, when not stalled.
- Pipeline control:
  - Each stage holds a valid bit v[k].
  - advance = !v[STAGES-1] || out_ready.
  - All stage registers load only when advance = 1 (global enable).
  - in_ready = advance (combinational from out_ready and v[last]).
  - A beat is accepted when in_valid && in_ready.
  - v[0] loads in_valid when advance = 1.
  - out_valid = v[STAGES-1].
- Stall: while out_valid && !out_ready, every register holds, out_sum stays stable, and in_ready = 0.
- Back-to-back: with out_ready held at 1, one beat is accepted per cycle and one result is produced per cycle (full throughput).
- Simultaneous events: the final stage draining while a new beat enters in the same cycle is legal and loses nothing.
- Bubbles propagate as invalid stages and are not collapsed.
- Reset (asynchronous, any time, including mid-operation):
  - all v[k] = 0, out_valid = 0, out_sum = 0, all data and carry registers = 0.
  - In-flight beats are discarded.
  - in_ready = 1 during and after reset, since it follows from v[last] = 0.
- STAGES = 1: one registered full-width ripple; latency 1.
- Data registers need not be reset for function, but are reset to 0 so waveform comparison is deterministic.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- Defined (saturating mode):
  - Add overflow (carry_out = 1): out_sum[WIDTH-1:0] = all ones.
  - Subtract underflow (borrow = 1): out_sum[WIDTH-1:0] = 0.
  - out_sum[WIDTH] = 1 whenever clamping occurred, else 0.
  - Clamp is applied combinationally at the last stage; latency is unchanged.
- Undefined: wrapping arithmetic as described above; the clamp logic is not present.

Decomposition:
- Package adder_pkg holds:
  - function seg_width(WIDTH, STAGES);
  - localparam constants for the add/sub mode encoding (MODE_ADD = 0, MODE_SUB = 1).
- Sub-module adder_seg: SEG-parameterised ripple of the existing adder_1bit cells, with cin/cout ports.
  - Instantiated once per stage via generate.
  - Purely combinational; all registers live in adder_pipe.

Test Plan (WIDTH=9, STAGES=3 unless noted):
- Add with carry: 511+1 -> out_sum = 10'h200 at exactly 3 cycles after acceptance; 0+0 -> 10'h000.
- Subtract: 7-5 -> 10'h002; 5-7 -> 10'h3FE (borrow = 1). With ADDER_PIPE_SAT_EN: 5-7 -> 10'h200, and 511+1 -> 10'h3FF.
- Streaming: 20 random beats back-to-back with out_ready = 1 -> one result per cycle, in order, each matching the reference model, with no gaps.
- Backpressure: drop out_ready for 4 cycles while the pipeline is full -> in_ready = 0, out_sum/out_valid held stable; after release, results drain in order with none lost or duplicated.
- Reset mid-flight: assert rst with 3 beats in flight -> out_valid = 0 and out_sum = 0 immediately (asynchronous, no clock edge needed); no stale result appears after rst deasserts.
- Parameter sweep: WIDTH=16 with STAGES=1, 4, 16 -> latency equals STAGES; 65535+65535 -> 17'h1FFFE.
